// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB front end of the I2C master: register map,
// CTRL/STATUS bit positions and the APB transfer FSM states.
package apb_i2c_pkg;
  localparam int OFF_DATA     = 0;
  localparam int OFF_CTRL     = 1;
  localparam int OFF_STATUS   = 2;
  localparam int OFF_PRESCALE = 3;
  localparam int OFF_SADDR    = 4;

  localparam int CTRL_EN    = 7;
  localparam int CTRL_RW    = 2;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_START = 0;

  localparam int ST_ACK_ERR  = 3;
  localparam int ST_BUSY     = 2;
  localparam int ST_RX_EMPTY = 1;
  localparam int ST_TX_FULL  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } apb_state_e;
endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for stalled APB transfers; saturates at WAIT_MAX and
// flags timeout once that many wait states have been inserted.
module apb_wait_timer #(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic timeout
);
  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CW'(WAIT_MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (cnt_q == CW'(WAIT_MAX));
endmodule

// File: rtl/apb_i2c_regfile.sv
// APB3 slave register file for the I2C master: register decode, FIFO wait
// states with bounded timeout, push/pop strobes and self-clearing START/STOP.
module apb_i2c_regfile
  import apb_i2c_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int PRESCALE_RST = 4,
  parameter int WAIT_MAX     = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              tx_full,
  input  logic              rx_empty,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              core_busy,
  input  logic              ack_err,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_push,
  output logic              rx_pop,
  output logic              start_pulse,
  output logic              stop_pulse,
  output logic              ctrl_en,
  output logic              ctrl_rw,
  output logic [DATA_W-1:0] prescale,
  output logic [6:0]        slave_addr
);
  apb_state_e        state_q, state_d;
  logic              ctrl_en_q, ctrl_en_d, ctrl_rw_q, ctrl_rw_d;
  logic [DATA_W-1:0] prescale_q, prescale_d, tx_data_q, tx_data_d;
  logic [6:0]        saddr_q, saddr_d;
  logic              tx_push_q, tx_push_d, start_q, start_d, stop_q, stop_d;

  logic sel_data, sel_ctrl, sel_stat, sel_pre, sel_sadr, unmapped;
  logic acc_err, blocked, ready, err, wait_inc, timeout;
  logic done_ok, wr_ok, rd_ok;
  logic [DATA_W-1:0] rd_val;

  assign sel_data = (PADDR == ADDR_W'(OFF_DATA));
  assign sel_ctrl = (PADDR == ADDR_W'(OFF_CTRL));
  assign sel_stat = (PADDR == ADDR_W'(OFF_STATUS));
  assign sel_pre  = (PADDR == ADDR_W'(OFF_PRESCALE));
  assign sel_sadr = (PADDR == ADDR_W'(OFF_SADDR));
  assign unmapped = ~(sel_data | sel_ctrl | sel_stat | sel_pre | sel_sadr);

  // Errors complete without waiting, even if the FIFO would otherwise stall.
  assign acc_err = unmapped | (PWRITE & sel_stat) | (PWRITE & sel_data & ~ctrl_en_q)
                 | (PWRITE & sel_pre & core_busy);
  assign blocked = sel_data & (PWRITE ? tx_full : rx_empty);

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    err      = 1'b0;
    wait_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) state_d = ACCESS;
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          if (acc_err) begin
            ready   = 1'b1;
            err     = 1'b1;
            state_d = IDLE;
          end else if (blocked) begin
            wait_inc = 1'b1;
            state_d  = WAIT;
          end else begin
            ready   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (!blocked) begin
          ready   = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          ready   = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  apb_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk    (PCLK),
    .rst    (PRESET),
    .clr    (~wait_inc),
    .inc    (wait_inc),
    .timeout(timeout)
  );

  assign done_ok = ready & ~err;
  assign wr_ok   = done_ok & PWRITE;
  assign rd_ok   = done_ok & ~PWRITE;

  always_comb begin
    rd_val = '0;
    if (sel_data) begin
      rd_val = rx_data;
    end else if (sel_ctrl) begin
      rd_val[CTRL_EN] = ctrl_en_q;
      rd_val[CTRL_RW] = ctrl_rw_q;
    end else if (sel_stat) begin
      rd_val[ST_ACK_ERR]  = ack_err;
      rd_val[ST_BUSY]     = core_busy;
      rd_val[ST_RX_EMPTY] = rx_empty;
      rd_val[ST_TX_FULL]  = tx_full;
    end else if (sel_pre) begin
      rd_val = prescale_q;
    end else if (sel_sadr) begin
      rd_val[6:0] = saddr_q;
    end
  end

  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    ctrl_rw_d  = ctrl_rw_q;
    prescale_d = prescale_q;
    saddr_d    = saddr_q;
    tx_data_d  = tx_data_q;
    tx_push_d  = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    if (wr_ok) begin
      if (sel_data) begin
        tx_data_d = PWDATA;
        tx_push_d = 1'b1;
      end
      if (sel_ctrl) begin
        ctrl_en_d = PWDATA[CTRL_EN];
        ctrl_rw_d = PWDATA[CTRL_RW];
        start_d   = PWDATA[CTRL_START];
        stop_d    = PWDATA[CTRL_STOP] & ~PWDATA[CTRL_START];
      end
      if (sel_pre)  prescale_d = PWDATA;
      if (sel_sadr) saddr_d    = PWDATA[6:0];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      ctrl_en_q  <= 1'b0;
      ctrl_rw_q  <= 1'b0;
      prescale_q <= DATA_W'(PRESCALE_RST);
      saddr_q    <= '0;
      tx_data_q  <= '0;
      tx_push_q  <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_en_q  <= ctrl_en_d;
      ctrl_rw_q  <= ctrl_rw_d;
      prescale_q <= prescale_d;
      saddr_q    <= saddr_d;
      tx_data_q  <= tx_data_d;
      tx_push_q  <= tx_push_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  // tx_push and tx_data are captured on the same edge so the FIFO sees them aligned.
  assign PREADY      = ready;
  assign PSLVERR     = err;
  assign PRDATA      = rd_ok ? rd_val : '0;
  assign rx_pop      = rd_ok & sel_data;
  assign tx_data     = tx_data_q;
  assign tx_push     = tx_push_q;
  assign start_pulse = start_q;
  assign stop_pulse  = stop_q;
  assign ctrl_en     = ctrl_en_q;
  assign ctrl_rw     = ctrl_rw_q;
  assign prescale    = prescale_q;
  assign slave_addr  = saddr_q;
endmodule

// File: tb/tb_apb_i2c_regfile.sv
// Directed bench for apb_i2c_regfile: APB transfers with hand-computed results.
module tb_apb_i2c_regfile;
  logic       PCLK = 1'b0;
  logic       PRESET, PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA;
  logic       PREADY, PSLVERR;
  logic       tx_full, rx_empty, core_busy, ack_err;
  logic [7:0] rx_data, tx_data, prescale;
  logic       tx_push, rx_pop, start_pulse, stop_pulse, ctrl_en, ctrl_rw;
  logic [6:0] slave_addr;

  int checks = 0;
  int passed = 0;
  int push_cnt = 0, pop_cnt = 0, start_cnt = 0, stop_cnt = 0;
  logic [7:0] last_tx = 8'h00;

  apb_i2c_regfile #(.DATA_W(8), .ADDR_W(8), .PRESCALE_RST(4), .WAIT_MAX(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_full(tx_full), .rx_empty(rx_empty), .rx_data(rx_data), .core_busy(core_busy),
    .ack_err(ack_err), .tx_data(tx_data), .tx_push(tx_push), .rx_pop(rx_pop),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse), .ctrl_en(ctrl_en),
    .ctrl_rw(ctrl_rw), .prescale(prescale), .slave_addr(slave_addr)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (tx_push) begin
      push_cnt++;
      last_tx = tx_data;
    end
    if (rx_pop) pop_cnt++;
    if (start_pulse) start_cnt++;
    if (stop_pulse) stop_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                     output logic [7:0] rd, output logic er, output int nwait);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    nwait = 0;
    @(negedge PCLK);
    while (!PREADY && nwait < 40) begin
      nwait++;
      @(negedge PCLK);
    end
    chk("xfer_done", {31'b0, PREADY}, 32'd1);
    rd = PRDATA;
    er = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;
    int         nw, p0, q0, s0, t0;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h00; PWDATA = 8'h00; tx_full = 1'b0; rx_empty = 1'b1;
    rx_data = 8'h00; core_busy = 1'b0; ack_err = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_pready", {31'b0, PREADY}, 32'd0);
    chk("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    chk("rst_prdata", {24'b0, PRDATA}, 32'h00);
    chk("rst_prescale", {24'b0, prescale}, 32'h04);
    chk("rst_ctrl_en", {31'b0, ctrl_en}, 32'd0);
    chk("rst_saddr", {25'b0, slave_addr}, 32'h00);
    chk("rst_tx_push", {31'b0, tx_push}, 32'd0);

    apb(1'b0, 8'h03, 8'h00, rd, er, nw);
    chk("rd_prescale", {24'b0, rd}, 32'h04);
    chk("rd_prescale_err", {31'b0, er}, 32'd0);
    chk("rd_prescale_wait", nw, 32'd0);

    apb(1'b0, 8'h02, 8'h00, rd, er, nw);
    chk("rd_status_idle", {24'b0, rd}, 32'h02);

    ack_err = 1'b1; core_busy = 1'b1; tx_full = 1'b1; rx_empty = 1'b0;
    apb(1'b0, 8'h02, 8'h00, rd, er, nw);
    chk("rd_status_busy", {24'b0, rd}, 32'h0D);
    ack_err = 1'b0; core_busy = 1'b0; tx_full = 1'b0; rx_empty = 1'b1;

    apb(1'b1, 8'h01, 8'h80, rd, er, nw);
    chk("wr_ctrl_err", {31'b0, er}, 32'd0);
    chk("ctrl_en_set", {31'b0, ctrl_en}, 32'd1);

    p0 = push_cnt;
    apb(1'b1, 8'h00, 8'hA5, rd, er, nw);
    repeat (2) @(negedge PCLK);
    chk("wr_data_wait", nw, 32'd0);
    chk("wr_data_err", {31'b0, er}, 32'd0);
    chk("wr_data_push", push_cnt - p0, 32'd1);
    chk("wr_data_txdata", {24'b0, last_tx}, 32'hA5);

    q0 = pop_cnt;
    fork
      apb(1'b0, 8'h00, 8'h00, rd, er, nw);
      begin
        repeat (5) @(posedge PCLK);
        #1 rx_data = 8'h3C; rx_empty = 1'b0;
      end
    join
    rx_empty = 1'b1;
    chk("rd_data_wait", nw, 32'd3);
    chk("rd_data_val", {24'b0, rd}, 32'h3C);
    chk("rd_data_err", {31'b0, er}, 32'd0);
    chk("rd_data_pop", pop_cnt - q0, 32'd1);

    p0 = push_cnt;
    tx_full = 1'b1;
    apb(1'b1, 8'h00, 8'h11, rd, er, nw);
    tx_full = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("tmo_wait", nw, 32'd16);
    chk("tmo_err", {31'b0, er}, 32'd1);
    chk("tmo_no_push", push_cnt - p0, 32'd0);

    s0 = start_cnt; t0 = stop_cnt;
    apb(1'b1, 8'h01, 8'h83, rd, er, nw);
    repeat (2) @(negedge PCLK);
    chk("start_once", start_cnt - s0, 32'd1);
    chk("start_no_stop", stop_cnt - t0, 32'd0);
    apb(1'b0, 8'h01, 8'h00, rd, er, nw);
    chk("ctrl_readback", {24'b0, rd}, 32'h80);

    s0 = start_cnt; t0 = stop_cnt;
    apb(1'b1, 8'h01, 8'h86, rd, er, nw);
    repeat (2) @(negedge PCLK);
    chk("stop_once", stop_cnt - t0, 32'd1);
    chk("stop_no_start", start_cnt - s0, 32'd0);
    chk("ctrl_rw_set", {31'b0, ctrl_rw}, 32'd1);
    apb(1'b0, 8'h01, 8'h00, rd, er, nw);
    chk("ctrl_rw_readback", {24'b0, rd}, 32'h84);
    apb(1'b1, 8'h01, 8'h80, rd, er, nw);

    apb(1'b1, 8'h02, 8'hFF, rd, er, nw);
    chk("wr_status_err", {31'b0, er}, 32'd1);
    apb(1'b0, 8'h02, 8'h00, rd, er, nw);
    chk("status_unchanged", {24'b0, rd}, 32'h02);

    apb(1'b0, 8'h07, 8'h00, rd, er, nw);
    chk("unmapped_err", {31'b0, er}, 32'd1);
    chk("unmapped_data", {24'b0, rd}, 32'h00);
    chk("unmapped_wait", nw, 32'd0);

    core_busy = 1'b1;
    apb(1'b1, 8'h03, 8'h20, rd, er, nw);
    chk("pre_busy_err", {31'b0, er}, 32'd1);
    apb(1'b0, 8'h03, 8'h00, rd, er, nw);
    chk("pre_busy_kept", {24'b0, rd}, 32'h04);
    core_busy = 1'b0;
    apb(1'b1, 8'h03, 8'h09, rd, er, nw);
    chk("pre_wr_err", {31'b0, er}, 32'd0);
    chk("pre_wr_out", {24'b0, prescale}, 32'h09);

    apb(1'b1, 8'h04, 8'hD5, rd, er, nw);
    apb(1'b0, 8'h04, 8'h00, rd, er, nw);
    chk("saddr_readback", {24'b0, rd}, 32'h55);
    chk("saddr_out", {25'b0, slave_addr}, 32'h55);

    // PSEL dropped while stalled on an empty RX FIFO.
    q0 = pop_cnt;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("abort_stalled", {31'b0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("abort_no_ready", {31'b0, PREADY}, 32'd0);
    chk("abort_no_pop", pop_cnt - q0, 32'd0);
    apb(1'b0, 8'h00, 8'h00, rd, er, nw);
    chk("abort_ctr_cleared", nw, 32'd16);
    chk("abort_tmo_err", {31'b0, er}, 32'd1);

    // Reset asserted while a TX write is stalled.
    p0 = push_cnt;
    tx_full = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 8'h77;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (4) @(negedge PCLK);
    chk("rstw_stalled", {31'b0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("rstw_pready", {31'b0, PREADY}, 32'd0);
    chk("rstw_pslverr", {31'b0, PSLVERR}, 32'd0);
    chk("rstw_prescale", {24'b0, prescale}, 32'h04);
    chk("rstw_ctrl_en", {31'b0, ctrl_en}, 32'd0);
    chk("rstw_tx_data", {24'b0, tx_data}, 32'h00);
    chk("rstw_saddr", {25'b0, slave_addr}, 32'h00);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b0; tx_full = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("rstw_no_push", push_cnt - p0, 32'd0);

    p0 = push_cnt;
    apb(1'b1, 8'h00, 8'h5A, rd, er, nw);
    repeat (2) @(negedge PCLK);
    chk("data_dis_err", {31'b0, er}, 32'd1);
    chk("data_dis_no_push", push_cnt - p0, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
